// File: rtl/swo_pkg.sv
// Shared encodings for the SWO byte-layer controller: mode inputs, active
// source codes and controller states.
package swo_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_MANCH = 2'd1;
  localparam logic [1:0] MODE_NRZ   = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'd3;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_MANCH = 2'd1;
  localparam logic [1:0] SRC_NRZ   = 2'd2;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ARM  = 2'd1,
    ST_HUNT = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

endpackage

// File: rtl/swo_byte_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on headData.
// A push while full is only taken when a pop frees a slot in the same cycle.
module swo_byte_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] pushData,
  input  logic          pop,
  output logic [DW-1:0] headData,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  assign count    = count_q;
  assign headData = mem[rdPtr_q];
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= pushData;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + ONE_PTR;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + ONE_PTR;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/swo_rx_ctrl.sv
// SWO byte-layer controller: picks the Manchester or NRZ decoder, turns their
// avail toggles into FIFO writes and hands bytes upward on valid/ready.
module swo_rx_ctrl
  import swo_pkg::*;
#(
  parameter int FIFO_AW    = 4,
  parameter int IDLE_TICKS = 4096,
  parameter int OVF_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             manchAvail,
  input  logic [7:0]       manchByte,
  input  logic             nrzAvail,
  input  logic [7:0]       nrzByte,
  output logic             outValid,
  output logic [7:0]       outData,
  input  logic             outReady,
  output logic [1:0]       activeSrc,
  output logic             idle,
  output logic [OVF_W-1:0] overflowCnt
);

  localparam int IW = $clog2(IDLE_TICKS);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TICKS - 1);
  localparam logic [IW-1:0] IDLE_ONE = IW'(1);
  localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       modeReg_q, modeReg_d;
  logic [1:0]       src_q, src_d;
  logic             availM_q, availN_q;
  logic             prevM_q, prevN_q;
  logic [7:0]       byteM_q, byteN_q;
  logic [IW-1:0]    idleCnt_q;
  logic [OVF_W-1:0] ovf_q;
  logic [7:0]       lastData_q;

  logic             evM, evN, idleSat;
  logic             accept, runEntry;
  logic [7:0]       acceptByte;
  logic             fifoPush, fifoPop, fifoFull, fifoEmpty, dropByte;
  logic [7:0]       fifoHead;
  logic [FIFO_AW:0] fifoCount;

  assign evM     = availM_q ^ prevM_q;
  assign evN     = availN_q ^ prevN_q;
  assign idleSat = (idleCnt_q == IDLE_MAX);

  always_comb begin
    state_d    = state_q;
    modeReg_d  = modeReg_q;
    src_d      = src_q;
    accept     = 1'b0;
    acceptByte = 8'h00;
    runEntry   = 1'b0;
    // A mode change overrides whatever the current state would have done.
    if (mode != modeReg_q) begin
      modeReg_d = mode;
      src_d     = SRC_NONE;
      state_d   = (mode == MODE_OFF) ? ST_OFF : ST_ARM;
    end else begin
      case (state_q)
        ST_OFF: src_d = SRC_NONE;
        ST_ARM: begin
          if (modeReg_q == MODE_AUTO) begin
            state_d = ST_HUNT;
            src_d   = SRC_NONE;
          end else begin
            state_d  = ST_RUN;
            src_d    = modeReg_q;
            runEntry = 1'b1;
          end
        end
        ST_HUNT: begin
          if (evM) begin
            accept     = 1'b1;
            acceptByte = byteM_q;
            src_d      = SRC_MANCH;
            state_d    = ST_RUN;
          end else if (evN) begin
            accept     = 1'b1;
            acceptByte = byteN_q;
            src_d      = SRC_NRZ;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (src_q == SRC_MANCH && evM) begin
            accept     = 1'b1;
            acceptByte = byteM_q;
          end else if (src_q == SRC_NRZ && evN) begin
            accept     = 1'b1;
            acceptByte = byteN_q;
          end else if (idleSat && modeReg_q == MODE_AUTO) begin
            state_d = ST_HUNT;
            src_d   = SRC_NONE;
          end
        end
        default: begin
          state_d = ST_OFF;
          src_d   = SRC_NONE;
        end
      endcase
    end
  end

  assign fifoPop  = outValid && outReady;
  assign fifoPush = accept && (!fifoFull || fifoPop);
  assign dropByte = accept && fifoFull && !fifoPop;

  // Avail lines and bytes are registered once, so a toggle is detected one
  // edge after it is sampled; prev follows in every state so ARM can discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OFF;
      modeReg_q  <= MODE_OFF;
      src_q      <= SRC_NONE;
      availM_q   <= 1'b0;
      availN_q   <= 1'b0;
      prevM_q    <= 1'b0;
      prevN_q    <= 1'b0;
      byteM_q    <= 8'h00;
      byteN_q    <= 8'h00;
      idleCnt_q  <= '0;
      ovf_q      <= '0;
      lastData_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      modeReg_q <= modeReg_d;
      src_q     <= src_d;
      availM_q  <= manchAvail;
      availN_q  <= nrzAvail;
      prevM_q   <= availM_q;
      prevN_q   <= availN_q;
      byteM_q   <= manchByte;
      byteN_q   <= nrzByte;
      if (accept || runEntry) begin
        idleCnt_q <= '0;
      end else if (!idleSat) begin
        idleCnt_q <= idleCnt_q + IDLE_ONE;
      end
      if (dropByte && ovf_q != '1) begin
        ovf_q <= ovf_q + OVF_ONE;
      end
      if (fifoCount != '0) begin
        lastData_q <= fifoHead;
      end
    end
  end

  swo_byte_fifo #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushData (acceptByte),
    .pop      (fifoPop),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign outValid    = !fifoEmpty;
  assign outData     = fifoEmpty ? lastData_q : fifoHead;
  assign activeSrc   = src_q;
  assign idle        = idleSat || (state_q != ST_RUN);
  assign overflowCnt = ovf_q;

endmodule

// File: tb/tb_swo_rx_ctrl.sv
// Directed bench for swo_rx_ctrl: a per-cycle vector table for source
// selection and idle unlock, then hand-written overflow/mode/reset sequences.
module tb_swo_rx_ctrl;

  localparam int IDLE_T = 8;
  localparam int OVF_W  = 16;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic             manchAvail;
  logic [7:0]       manchByte;
  logic             nrzAvail;
  logic [7:0]       nrzByte;
  logic             outValid;
  logic [7:0]       outData;
  logic             outReady;
  logic [1:0]       activeSrc;
  logic             idle;
  logic [OVF_W-1:0] overflowCnt;

  int checks;
  int failures;

  typedef struct {
    logic [1:0] mode;
    logic       togM;
    logic [7:0] byteM;
    logic       togN;
    logic [7:0] byteN;
    logic       ready;
    logic       expValid;
    logic [7:0] expData;
    logic [1:0] expSrc;
    logic       expIdle;
  } vec_t;

  vec_t vecs [20];

  swo_rx_ctrl #(
    .FIFO_AW    (4),
    .IDLE_TICKS (IDLE_T),
    .OVF_W      (OVF_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .manchAvail  (manchAvail),
    .manchByte   (manchByte),
    .nrzAvail    (nrzAvail),
    .nrzByte     (nrzByte),
    .outValid    (outValid),
    .outData     (outData),
    .outReady    (outReady),
    .activeSrc   (activeSrc),
    .idle        (idle),
    .overflowCnt (overflowCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    mode = v.mode;
    if (v.togM) manchAvail = ~manchAvail;
    manchByte = v.byteM;
    if (v.togN) nrzAvail = ~nrzAvail;
    nrzByte  = v.byteN;
    outReady = v.ready;
  endtask

  task automatic pushNrz(input logic [7:0] b);
    nrzAvail = ~nrzAvail;
    nrzByte  = b;
    tick();
  endtask

  task automatic pushManch(input logic [7:0] b);
    manchAvail = ~manchAvail;
    manchByte  = b;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    mode       = 2'd0;
    manchAvail = 1'b1;
    manchByte  = 8'h00;
    nrzAvail   = 1'b0;
    nrzByte    = 8'h00;
    outReady   = 1'b0;

    //               mode tM bM     tN bN     rdy  eV  eD     eS  eI
    vecs[0]  = '{2'd1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 2'd0, 1};
    vecs[1]  = '{2'd1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 2'd1, 0};
    vecs[2]  = '{2'd1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 2'd1, 0};
    vecs[3]  = '{2'd1, 1, 8'hA5, 0, 8'h00, 0,   0, 8'h00, 2'd1, 0};
    vecs[4]  = '{2'd1, 0, 8'hA5, 0, 8'h00, 0,   1, 8'hA5, 2'd1, 0};
    vecs[5]  = '{2'd1, 0, 8'hA5, 0, 8'h00, 1,   0, 8'hA5, 2'd1, 0};
    vecs[6]  = '{2'd3, 0, 8'hA5, 0, 8'h00, 1,   0, 8'hA5, 2'd0, 1};
    vecs[7]  = '{2'd3, 1, 8'h11, 1, 8'h22, 0,   0, 8'hA5, 2'd0, 1};
    vecs[8]  = '{2'd3, 0, 8'h11, 0, 8'h22, 0,   1, 8'h11, 2'd1, 0};
    vecs[9]  = '{2'd3, 0, 8'h11, 1, 8'h33, 0,   1, 8'h11, 2'd1, 0};
    vecs[10] = '{2'd3, 0, 8'h11, 0, 8'h33, 0,   1, 8'h11, 2'd1, 0};
    vecs[11] = '{2'd3, 0, 8'h11, 0, 8'h33, 1,   0, 8'h11, 2'd1, 0};
    vecs[12] = '{2'd3, 0, 8'h11, 0, 8'h33, 0,   0, 8'h11, 2'd1, 0};
    vecs[13] = '{2'd3, 0, 8'h11, 0, 8'h33, 0,   0, 8'h11, 2'd1, 0};
    vecs[14] = '{2'd3, 0, 8'h11, 0, 8'h33, 0,   0, 8'h11, 2'd1, 0};
    vecs[15] = '{2'd3, 0, 8'h11, 0, 8'h33, 0,   0, 8'h11, 2'd1, 1};
    vecs[16] = '{2'd3, 0, 8'h11, 0, 8'h33, 0,   0, 8'h11, 2'd0, 1};
    vecs[17] = '{2'd3, 0, 8'h11, 1, 8'h5A, 0,   0, 8'h11, 2'd0, 1};
    vecs[18] = '{2'd3, 0, 8'h11, 0, 8'h5A, 0,   1, 8'h5A, 2'd2, 0};
    vecs[19] = '{2'd3, 0, 8'h11, 0, 8'h5A, 1,   0, 8'h5A, 2'd2, 0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outValid", int'(outValid), 0);
    checkOutput("reset outData", int'(outData), 0);
    checkOutput("reset activeSrc", int'(activeSrc), 0);
    checkOutput("reset idle", int'(idle), 1);
    checkOutput("reset overflowCnt", int'(overflowCnt), 0);
    rst = 1'b0;

    // Manchester path, auto-mode tie-break, idle unlock and relock to NRZ.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d outValid", i), int'(outValid), int'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d outData", i), int'(outData), int'(vecs[i].expData));
      checkOutput($sformatf("vec%0d activeSrc", i), int'(activeSrc), int'(vecs[i].expSrc));
      checkOutput($sformatf("vec%0d idle", i), int'(idle), int'(vecs[i].expIdle));
    end

    // NRZ overflow: 20 bytes into a 16-deep FIFO with the consumer stalled.
    outReady = 1'b0;
    mode = 2'd2;
    tick();
    tick();
    checkOutput("nrz lock activeSrc", int'(activeSrc), 2);
    for (int i = 0; i < 20; i++) pushNrz(8'(i));
    tick();
    tick();
    checkOutput("ovf count", int'(overflowCnt), 4);
    checkOutput("ovf head valid", int'(outValid), 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall data %0d", i), int'(outData), 0);
      tick();
    end
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain valid %0d", i), int'(outValid), 1);
      checkOutput($sformatf("drain data %0d", i), int'(outData), i);
      tick();
    end
    checkOutput("drain empty", int'(outValid), 0);
    outReady = 1'b0;

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 17; i++) pushNrz(8'(8'h40 + i));
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("full push+pop ovf", int'(overflowCnt), 4);
    checkOutput("full push+pop head", int'(outData), 8'h41);
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("full drain valid %0d", i), int'(outValid), 1);
      checkOutput($sformatf("full drain data %0d", i), int'(outData), 8'h41 + i);
      tick();
    end
    checkOutput("full drain empty", int'(outValid), 0);
    outReady = 1'b0;

    // Mode change 1 -> 2 keeps queued bytes; Manchester toggle in ARM is lost.
    mode = 2'd1;
    tick();
    tick();
    pushManch(8'hC1);
    pushManch(8'hC2);
    pushManch(8'hC3);
    tick();
    tick();
    mode       = 2'd2;
    manchAvail = ~manchAvail;
    manchByte  = 8'hEE;
    tick();
    checkOutput("arm activeSrc", int'(activeSrc), 0);
    tick();
    checkOutput("post-arm activeSrc", int'(activeSrc), 2);
    tick();
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("queued valid %0d", i), int'(outValid), 1);
      checkOutput($sformatf("queued data %0d", i), int'(outData), 8'hC1 + i);
      tick();
    end
    checkOutput("queued empty", int'(outValid), 0);
    outReady = 1'b0;
    pushNrz(8'h77);
    tick();
    checkOutput("nrz after change valid", int'(outValid), 1);
    checkOutput("nrz after change data", int'(outData), 8'h77);
    checkOutput("ovf before reset", int'(overflowCnt), 4);

    // Asynchronous reset mid-stream with a head pending.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset outValid", int'(outValid), 0);
    checkOutput("midreset overflowCnt", int'(overflowCnt), 0);
    checkOutput("midreset activeSrc", int'(activeSrc), 0);
    checkOutput("midreset idle", int'(idle), 1);
    checkOutput("midreset outData", int'(outData), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
